// File: rtl/pulse_train_driver_pkg.sv
// Purpose: shared phase-state encoding, minimum-hold depth and length clamp for pin drivers/debouncers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Ports: none (package). MIN_HOLD_DEFAULT must match the far-end debounce depth.
package pulse_train_driver_pkg;

  // One value shared with the board input debouncers so both ends agree on depth.
  localparam int MIN_HOLD_DEFAULT = 3;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] ACTIVE_ENC = 2'd1;
  localparam logic [1:0] GAP_ENC    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    ACTIVE = ACTIVE_ENC,
    GAP    = GAP_ENC
  } state_t;

  // Phase lengths below the hold depth (including 0) are raised to it.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] min_hold);
    return (len < min_hold) ? min_hold : len;
  endfunction

endpackage

// File: rtl/pulse_train_driver_if.sv
// Purpose: control/status bundle between register logic and pulse_train_driver.
// Latency: n/a (wires only).
// Backpressure: none; start is only taken while busy=0, abort only while busy=1.
// Signals: start/high_len/low_len/count/abort (control -> driver), out/busy/done (driver -> control/pad).
interface pulse_train_driver_if #(
  parameter int CNT_WIDTH = 16,
  parameter int N_WIDTH   = 8
);
  logic                 start;
  logic [CNT_WIDTH-1:0] high_len;
  logic [CNT_WIDTH-1:0] low_len;
  logic [N_WIDTH-1:0]   count;
  logic                 abort;
  logic                 out;
  logic                 busy;
  logic                 done;

  modport master (
    output start, high_len, low_len, count, abort,
    input  out, busy, done
  );

  modport slave (
    input  start, high_len, low_len, count, abort,
    output out, busy, done
  );
endinterface

// File: rtl/pulse_train_driver_hold_timer.sv
// Purpose: loadable phase down-counter with an early-stop that never cuts a phase below MIN_HOLD.
// Latency: expire asserts in the Nth cycle after a load of N (or on stop once MIN_HOLD cycles elapsed).
// Backpressure: none; load always wins over counting.
// Ports: clk, rst, load (strobe), load_val (phase length >= 1), stop (early-stop request), expire (strobe).
module pulse_train_driver_hold_timer
  import pulse_train_driver_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int MIN_HOLD  = MIN_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 stop,
  output logic                 expire
);

  localparam logic [CNT_WIDTH-1:0] HOLD = CNT_WIDTH'(MIN_HOLD);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] remain;   // cycles left in the phase, including the current one
  logic [CNT_WIDTH-1:0] elapsed;  // cycles spent in the phase, saturating at MIN_HOLD

  always_ff @(posedge clk) begin
    if (rst) begin
      remain  <= '0;
      elapsed <= '0;
    end else if (load) begin
      remain  <= load_val;
      elapsed <= ONE;
    end else begin
      if (remain != '0) remain <= remain - ONE;
      if (remain != '0 && elapsed < HOLD) elapsed <= elapsed + ONE;
    end
  end

  assign expire = (remain == ONE) || ((remain != '0) && stop && (elapsed >= HOLD));

endmodule

// File: rtl/pulse_train_driver.sv
// Purpose: drives one pin with N pulses of H active / L idle clocks, every level held >= MIN_HOLD.
// Latency: first active level one clock after start; done one clock after the last gap cycle.
// Backpressure: start ignored while busy; abort (sticky) ends the train after the current/next full gap.
// Ports: clk, rst (sync, active-high), bus (slave modport: start/high_len/low_len/count/abort in; out/busy/done out).
module pulse_train_driver
  import pulse_train_driver_pkg::*;
#(
  parameter int   MIN_HOLD   = MIN_HOLD_DEFAULT,
  parameter int   CNT_WIDTH  = 16,
  parameter int   N_WIDTH    = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_train_driver_if.slave   bus
);

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] h_q, h_nx;
  logic [CNT_WIDTH-1:0] l_q, l_nx;
  logic [N_WIDTH-1:0]   pulses_q, pulses_nx;
  logic                 pend_q, pend_nx;
  logic                 done_nx;
  logic                 out_q, busy_q, done_q;

  logic                 tmr_load;
  logic [CNT_WIDTH-1:0] tmr_val;
  logic                 tmr_stop;
  logic                 tmr_expire;

  logic [CNT_WIDTH-1:0] h_eff, l_eff;
  logic                 abort_any;

  assign h_eff     = CNT_WIDTH'(clamp_len(32'(bus.high_len), 32'(MIN_HOLD)));
  assign l_eff     = CNT_WIDTH'(clamp_len(32'(bus.low_len), 32'(MIN_HOLD)));
  // An abort arriving this cycle acts immediately, not one clock late via the flag.
  assign abort_any = pend_q | bus.abort;

  pulse_train_driver_hold_timer #(
    .CNT_WIDTH (CNT_WIDTH),
    .MIN_HOLD  (MIN_HOLD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .stop     (tmr_stop),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      h_q      <= '0;
      l_q      <= '0;
      pulses_q <= '0;
      pend_q   <= 1'b0;
      out_q    <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      h_q      <= h_nx;
      l_q      <= l_nx;
      pulses_q <= pulses_nx;
      pend_q   <= pend_nx;
      // Pin and status come straight from flops decoded off the next state.
      out_q    <= (state_nx == ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
      busy_q   <= (state_nx != IDLE);
      done_q   <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    h_nx      = h_q;
    l_nx      = l_q;
    pulses_nx = pulses_q;
    pend_nx   = pend_q;
    done_nx   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = h_q;
    tmr_stop  = 1'b0;

    case (state)
      IDLE: begin
        pend_nx = 1'b0;
        if (bus.start) begin
          if (bus.count != '0) begin
            h_nx      = h_eff;
            l_nx      = l_eff;
            pulses_nx = bus.count;
            tmr_load  = 1'b1;
            tmr_val   = h_eff;
            state_nx  = ACTIVE;
          end else begin
            done_nx = 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (bus.abort) pend_nx = 1'b1;
        tmr_stop = abort_any;
        if (tmr_expire) begin
          pulses_nx = pulses_q - N_WIDTH'(1);
          tmr_load  = 1'b1;
          tmr_val   = l_q;
          state_nx  = GAP;
        end
      end

      GAP: begin
        if (bus.abort) pend_nx = 1'b1;
        // Gaps always run to completion so the far end settles before done.
        if (tmr_expire) begin
          if (pulses_q != '0 && !abort_any) begin
            tmr_load = 1'b1;
            tmr_val  = h_q;
            state_nx = ACTIVE;
          end else begin
            pend_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end

      default: begin
        pend_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pulse_train_driver.sv
// Purpose: timeline-driven bench; a phase-list reference model predicts out/busy/done for every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_train_driver;
  import pulse_train_driver_pkg::*;

  localparam int MH   = 3;
  localparam int MAXC = 72000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_train_driver_if #(.CNT_WIDTH(16), .N_WIDTH(8)) bus_if ();

  pulse_train_driver #(
    .MIN_HOLD   (MH),
    .CNT_WIDTH  (16),
    .N_WIDTH    (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Stimulus per cycle c (sampled at edge c) and expectations per cycle m (after edge m-1).
  bit          st_start [MAXC];
  bit          st_abort [MAXC];
  bit          st_rst   [MAXC];
  logic [15:0] st_hl    [MAXC];
  logic [15:0] st_ll    [MAXC];
  logic [7:0]  st_cnt   [MAXC];
  bit          e_out    [MAXC];
  bit          e_busy   [MAXC];
  bit          e_done   [MAXC];
  logic [2:0]  obs      [MAXC];

  int tests = 0;
  int fails = 0;
  int len;
  int pos;
  int kn, kc, kz, ka, kb, kbb, kr, km, kl;

  // Far-end 3-deep debouncer on the pin.
  logic [2:0] dsh = 3'b000;
  logic       deb = 1'b0;
  int         deb_rises = 0;
  always @(posedge clk) begin
    dsh <= {dsh[1:0], bus_if.out};
    if (dsh == 3'b111 && !deb) begin
      deb       <= 1'b1;
      deb_rises <= deb_rises + 1;
    end else if (dsh == 3'b000) begin
      deb <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int dur(input int h, input int l, input int n);
    return (n == 0) ? 1 : n * (imax(h, MH) + imax(l, MH)) + 1;
  endfunction

  task automatic put_train(input int k, input int h, input int l, input int n);
    st_start[k] = 1'b1;
    st_hl[k]    = 16'(h);
    st_ll[k]    = 16'(l);
    st_cnt[k]   = 8'(n);
  endtask

  function automatic int first_done(input int from, input int upto);
    for (int m = from; m <= upto; m++) if (obs[m][0] === 1'b1) return m;
    return -1;
  endfunction

  function automatic int count_hi(input int from, input int upto);
    int s;
    s = 0;
    for (int m = from; m <= upto; m++) if (obs[m][2] === 1'b1) s++;
    return s;
  endfunction

  // Reference: walk the timeline, accept a start only when free, lay out the train as a phase list.
  task automatic build_expected();
    int free;
    free = 0;
    for (int c = 0; c < len; c++) begin
      int hh, ll, nn, ab, cur, d, lim, a;
      if (st_rst[c] || c < free || !st_start[c]) continue;
      nn = int'(st_cnt[c]);
      if (nn == 0) begin
        e_done[c+1] = 1'b1;
        free = c + 1;
        continue;
      end
      hh  = imax(int'(st_hl[c]), MH);
      ll  = imax(int'(st_ll[c]), MH);
      lim = c + nn * (hh + ll);
      ab  = 0;
      for (int e = c + 1; e <= lim && e < len; e++) begin
        if (st_abort[e]) begin
          ab = e - c;
          break;
        end
      end
      cur = 1;
      for (int p = 0; p < nn; p++) begin
        a = hh;
        if (ab != 0 && ab >= cur && ab < cur + hh) a = imin(hh, imax(MH, ab - cur + 1));
        for (int i = 0; i < a; i++) e_out[c+cur+i] = 1'b1;
        cur = cur + a + ll;
        if (ab != 0 && ab < cur) break;
      end
      d = cur;
      for (int m = c + 1; m < c + d; m++) e_busy[m] = 1'b1;
      e_done[c+d] = 1'b1;
      free = c + d;
      for (int e = c + 1; e < c + d; e++) begin
        if (st_rst[e]) begin
          for (int m = e + 1; m <= c + d; m++) begin
            e_out[m]  = 1'b0;
            e_busy[m] = 1'b0;
            e_done[m] = 1'b0;
          end
          free = e + 1;
          break;
        end
      end
    end
  endtask

  task automatic drive(input int c);
    rst             = st_rst[c];
    bus_if.start    = st_start[c];
    bus_if.abort    = st_abort[c];
    bus_if.high_len = st_hl[c];
    bus_if.low_len  = st_ll[c];
    bus_if.count    = st_cnt[c];
  endtask

  initial begin
    int exp_rises, h, l, n, d;

    for (int c = 0; c < MAXC; c++) begin
      st_hl[c]  = 16'($urandom);
      st_ll[c]  = 16'($urandom);
      st_cnt[c] = 8'($urandom);
    end
    st_rst[0] = 1'b1;
    st_rst[1] = 1'b1;

    kn = 4;        put_train(kn, 5, 4, 3);  st_start[kn+10] = 1'b1;
    kc = kn + 31;  put_train(kc, 0, 1, 2);
    kz = kc + 15;  put_train(kz, 9, 9, 0);
    ka = kz + 3;   put_train(ka, 20, 4, 5); st_abort[ka] = 1'b1; st_abort[ka+1] = 1'b1;
    kb = ka + 10;  put_train(kb, 4, 6, 5);  st_abort[kb+6] = 1'b1;
    kbb = kb + 12; put_train(kbb, 3, 3, 2); put_train(kbb + 13, 4, 5, 1);
    kr = kbb + 25; put_train(kr, 10, 3, 2); st_rst[kr+5] = 1'b1;
    pos = kr + 12;

    for (int r = 0; r < 40; r++) begin
      h = $urandom_range(0, 7);
      l = $urandom_range(0, 7);
      n = $urandom_range(0, 4);
      put_train(pos, h, l, n);
      d = dur(h, l, n);
      if (n > 0 && $urandom_range(0, 3) == 0)
        st_abort[pos + $urandom_range(1, d - 1)] = 1'b1;
      else if (n > 0 && $urandom_range(0, 2) == 0)
        st_start[pos + $urandom_range(1, d - 1)] = 1'b1;
      pos = pos + d + $urandom_range(0, 3);
    end

    km = pos;      put_train(km, 3, 3, 255);
    kl = km + 1532; put_train(kl, 65535, 0, 1);
    pos = kl + 65540;
    len = pos + 10;

    build_expected();
    exp_rises = 0;
    for (int m = 2; m < len; m++) if (e_out[m] && !e_out[m-1]) exp_rises++;

    drive(0);
    for (int c = 0; c < len - 1; c++) begin
      @(posedge clk);
      #1;
      obs[c+1] = {bus_if.out, bus_if.busy, bus_if.done};
      chk($sformatf("cyc%0d", c + 1), 32'(obs[c+1]),
          {29'd0, e_out[c+1], e_busy[c+1], e_done[c+1]});
      drive(c + 1);
    end
    repeat (4) @(posedge clk);
    #1;

    chk("reset_state", 32'(obs[2]), 32'd0);
    chk("nom_done", first_done(kn + 1, kn + 60), kn + 28);
    chk("nom_hi_k1", 32'(obs[kn+1][2]), 32'd1);
    chk("nom_lo_k6", 32'(obs[kn+6][2]), 32'd0);
    chk("nom_hi_k23", 32'(obs[kn+23][2]), 32'd1);
    chk("nom_lo_k24", 32'(obs[kn+24][2]), 32'd0);
    chk("nom_busy_k27", 32'(obs[kn+27][1]), 32'd1);
    chk("nom_busy_k28", 32'(obs[kn+28][1]), 32'd0);
    chk("nom_hi_total", count_hi(kn + 1, kn + 28), 15);
    chk("clamp_done", first_done(kc + 1, kc + 40), kc + 13);
    chk("clamp_hi_total", count_hi(kc + 1, kc + 13), 6);
    chk("zero_done", first_done(kz + 1, kz + 2), kz + 1);
    chk("zero_no_pulse", count_hi(kz + 1, kz + 2), 0);
    chk("abort_act_done", first_done(ka + 1, ka + 200), ka + 8);
    chk("abort_act_hi", count_hi(ka + 1, ka + 8), 3);
    chk("abort_gap_done", first_done(kb + 1, kb + 100), kb + 11);
    chk("abort_gap_hi", count_hi(kb + 1, kb + 11), 4);
    chk("b2b_done1", first_done(kbb + 1, kbb + 20), kbb + 13);
    chk("b2b_second_hi", 32'(obs[kbb+14][2]), 32'd1);
    chk("b2b_done2", first_done(kbb + 14, kbb + 30), kbb + 23);
    chk("rst_mid_out", 32'(obs[kr+6]), 32'd0);
    chk("rst_mid_nodone", first_done(kr + 1, kr + 11), -1);
    chk("max_cnt_done", first_done(km + 1, km + 1600), km + 1531);
    chk("max_len_done", first_done(kl + 1, kl + 65600), kl + 65539);
    chk("deb_pulses", deb_rises, exp_rises);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
